uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL expose parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal 2..8).
REQ-002 The block SHALL expose parameter FRAME_CYCLES, default 11, clock cycles one TX frame occupies, including the o_tx_start cycle (legal 2..255).
REQ-003 The block SHALL expose parameter GAP_CYCLES, default 1, idle cycles inserted after each frame (legal 0..255).
REQ-004 The block SHALL provide the following ports; IDW = max(1, $clog2(NUM_REQ)):
 i_clk  in  1  clock; all logic on rising edge
 i_rst_n  in  1  reset, asynchronous, active-low
 i_req_valid  in  NUM_REQ  per-requester byte valid
 i_req_data  in  NUM_REQ*8  byte of requester k in bits [8k+7:8k]
 o_req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
 i_pause  in  1  high blocks new grants; does not abort a frame in flight
 o_tx_start  out  1  one-cycle launch pulse to the transmitter
 o_tx_data  out  8  byte to the transmitter, stable from launch to end of frame
 o_grant_id  out  IDW  index of the requester owning the current frame
 o_busy  out  1  high whenever the state is not IDLE
 o_frame_done  out  1  one-cycle pulse in the last cycle of a frame

Function
REQ-005 The FSM SHALL have states IDLE, LAUNCH, WAIT, GAP.
REQ-006 In IDLE with i_pause=0 and any i_req_valid bit high, the block SHALL grant exactly one requester via round-robin, searching from index (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-007 In the grant cycle, o_req_ready[g] SHALL be 1 combinationally; the byte SHALL be captured into the TX data register, g into o_grant_id, last_grant set to g, and the next state SHALL be LAUNCH.
REQ-008 o_req_ready SHALL be all-zero in every state other than IDLE, and in IDLE when i_pause=1 or no valid is high.
REQ-009 LAUNCH SHALL last exactly one cycle with o_tx_start=1, then go to WAIT; o_tx_start SHALL be 0 in all other states.
REQ-010 If T is the LAUNCH cycle, WAIT SHALL occupy cycles T+1..T+FRAME_CYCLES-1; o_frame_done SHALL be 1 only in cycle T+FRAME_CYCLES-1.
REQ-011 After WAIT the FSM SHALL enter GAP for GAP_CYCLES cycles, then IDLE; with GAP_CYCLES=0 it SHALL go directly from WAIT to IDLE.
REQ-012 Default timing: valid seen in IDLE at cycle 0 -> ready at 0, o_tx_start at 1, o_frame_done at 11, GAP at 12, next grant possible at 13.
REQ-013 o_tx_data and o_grant_id SHALL hold their values from LAUNCH until the next grant; changes on i_req_data after acceptance SHALL NOT affect the frame.
REQ-014 The frame/gap counter SHALL be 8 bits, SHALL clear on each state entry, and SHALL NOT wrap within a legal configuration.
REQ-015 i_pause rising during LAUNCH, WAIT or GAP SHALL NOT alter that frame; it SHALL only suppress grants while in IDLE.
REQ-016 A requester deasserting valid before ready SHALL simply not be considered; no partial state SHALL be retained for it.
REQ-017 With a single requester continuously valid, it SHALL be granted every frame; fairness SHALL be one frame per requester per round.

Reset
REQ-018 On i_rst_n low, asynchronously: state IDLE, counter 0, last_grant NUM_REQ-1 (index 0 highest priority first), o_tx_data 0, o_grant_id 0, o_tx_start 0, o_frame_done 0, o_busy 0, o_req_ready 0.
REQ-019 Reset asserted mid-frame SHALL abort immediately with no o_frame_done pulse; after release the first grant SHALL follow REQ-006 from index 0.

Verification
REQ-020 Single request: after reset, valid[2]=1 data 0xA5 at cycle 0 -> ready[2]=1 at 0, o_tx_start=1 and o_tx_data=0xA5 at 1, o_grant_id=2, o_frame_done at 11, o_busy low at 13.
REQ-021 Round-robin: all four valid continuously from reset -> grants in order 0,1,2,3,0, each launch spaced FRAME_CYCLES+GAP_CYCLES+1 = 13 cycles apart.
REQ-022 Wrap-around: last_grant=3, valid on 1 and 3 -> grant 1, then 3, then 1.
REQ-023 Pause: i_pause=1 with valid[0]=1 -> no ready, no start; pause asserted during WAIT -> frame completes with o_frame_done, no new grant until pause drops.
REQ-024 Reset mid-frame: i_rst_n low at cycle 5 of WAIT -> all outputs 0 immediately, no o_frame_done; after release, valid[3] and valid[0] -> grant 0 first.
REQ-025 GAP_CYCLES=0, FRAME_CYCLES=2: back-to-back requests from requester 1 -> o_tx_start every 3 cycles, o_frame_done one cycle after each start.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters.
// Each grant launches one frame, holds it for FRAME_CYCLES, then idles GAP_CYCLES before re-arbitrating.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned FRAME_CYCLES = 11,
  parameter int unsigned GAP_CYCLES   = 1,
  localparam int unsigned IDW         = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic                 i_pause,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic [IDW-1:0]       o_grant_id,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StGap} state_e;

  // WAIT spans FRAME_CYCLES-1 cycles, GAP spans GAP_CYCLES cycles; counter clears on entry
  localparam logic [7:0] LastWait = 8'(FRAME_CYCLES - 2);
  localparam logic [7:0] LastGap  = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e         r_state;
  logic [7:0]     r_cnt;
  logic [IDW-1:0] r_last;
  logic [7:0]     r_tx_data;
  logic [IDW-1:0] r_grant_id;
  logic           r_tx_start;
  logic           r_frame_done;
  logic           r_busy;

  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_gid;
  logic           w_found;
  logic           w_grant;
  logic [7:0]     w_data;

  // Search starts one past the last winner and wraps, so every requester gets a turn per round
  always_comb begin
    w_cand  = '0;
    w_gid   = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDW'((32'(r_last) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gid   = w_cand;
      end
    end
  end

  assign w_grant     = (r_state == StIdle) && !i_pause && w_found && i_rst_n;
  assign w_data      = i_req_data[8*w_gid +: 8];
  assign o_req_ready = w_grant ? (NUM_REQ'(1) << w_gid) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_last       <= IDW'(NUM_REQ - 1);
      r_tx_data    <= '0;
      r_grant_id   <= '0;
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_tx_data  <= w_data;
            r_grant_id <= w_gid;
            r_last     <= w_gid;
            r_state    <= StLaunch;
            r_cnt      <= '0;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        StLaunch: begin
          r_tx_start   <= 1'b0;
          r_state      <= StWait;
          r_cnt        <= '0;
          r_frame_done <= (FRAME_CYCLES == 2);
        end
        StWait: begin
          if (r_cnt == LastWait) begin
            r_frame_done <= 1'b0;
            r_cnt        <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_state <= StGap;
            end
          end else begin
            r_cnt        <= r_cnt + 8'd1;
            r_frame_done <= ((r_cnt + 8'd1) == LastWait);
          end
        end
        StGap: begin
          if (r_cnt == LastGap) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_grant_id   = r_grant_id;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule
